// File: rtl/pico_pkg.sv
// Shared types and helpers for the pico core.
// Holds the control-sequencer state encoding.
package pico_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALTED,
    S_FAULT
  } seqState;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by fetch timeout and execute latency.
// Load wins over decrement; decrement stops at zero.
module seq_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pico_seq.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for pico.
// Gates fetch, IR load, RF write and PC update; counts retirements.
module pico_seq
  import pico_pkg::*;
#(
  parameter int MUL_LAT   = 4,
  parameter int FETCH_TMO = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic             imem_ack_i,
  input  logic             mul_op_i,
  input  logic             wr_en_rf_i,
  input  logic             halt_core_i,
  output logic             imem_req_o,
  output logic             ir_load_o,
  output logic             alu_busy_o,
  output logic             rf_we_o,
  output logic             pc_en_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam int TW =
    max_i(1, $clog2(max_i(MUL_LAT, FETCH_TMO)));
  localparam logic [TW-1:0] TMO_V = TW'(FETCH_TMO - 1);
  localparam logic [TW-1:0] MUL_V = TW'(MUL_LAT - 1);

  if (MUL_LAT < 1 || FETCH_TMO < 1) begin : g_bad_param
    $error("pico_seq: MUL_LAT and FETCH_TMO must be >= 1");
  end

  seqState          state_q, state_d;
  logic             step_q, step_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             t_load, t_dec, t_zero;
  logic [TW-1:0]    t_val;

  seq_timer #(.W(TW)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (t_load),
    .val_i   (t_val),
    .dec_i   (t_dec),
    .zero_o  (t_zero)
  );

  // RF write enable is captured on EXEC exit so rf_we_o is purely registered
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    we_d    = we_q;
    ret_d   = ret_q;
    t_load  = 1'b0;
    t_dec   = 1'b0;
    t_val   = TMO_V;
    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_FETCH;
          step_d  = 1'b0;
          t_load  = 1'b1;
        end else if (step_i) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
          t_load  = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_ack_i)  state_d = S_DECODE;
        else if (t_zero) state_d = S_FAULT;
        else             t_dec   = 1'b1;
      end
      S_DECODE: begin
        if (halt_core_i) begin
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
          t_load  = 1'b1;
          t_val   = mul_op_i ? MUL_V : '0;
        end
      end
      S_EXEC: begin
        if (t_zero) begin
          state_d = S_WB;
          we_d    = wr_en_rf_i;
        end else begin
          t_dec = 1'b1;
        end
      end
      S_WB: begin
        if (~&ret_q) ret_d = ret_q + 1'b1;
        if (step_q || !run_i) begin
          state_d = S_IDLE;
          step_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
          t_load  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      we_q    <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      we_q    <= we_d;
      ret_q   <= ret_d;
    end
  end

  assign imem_req_o = (state_q == S_FETCH);
  assign ir_load_o  = imem_req_o & imem_ack_i;
  assign alu_busy_o = (state_q == S_EXEC);
  assign pc_en_o    = (state_q == S_WB);
  assign rf_we_o    = pc_en_o & we_q;
  assign fault_o    = (state_q == S_FAULT);
  assign halted_o   = fault_o | (state_q == S_HALTED);
  assign state_o    = state_q;
  assign retired_o  = ret_q;

endmodule

// File: tb/tb_pico_seq.sv
// Scoreboard bench for pico_seq: directed programs, decoupled WB monitor.
// Environment process plays instruction memory and decoder.
module tb_pico_seq;
  import pico_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i, run_i, step_i;
  logic        imem_ack_i, mul_op_i, wr_en_rf_i, halt_core_i;
  logic        imem_req_o, ir_load_o, alu_busy_o;
  logic        rf_we_o, pc_en_o, halted_o, fault_o;
  logic [2:0]  state_o;
  logic [15:0] retired_o;

  pico_seq #(.MUL_LAT(4), .FETCH_TMO(16), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .run_i       (run_i),
    .step_i      (step_i),
    .imem_ack_i  (imem_ack_i),
    .mul_op_i    (mul_op_i),
    .wr_en_rf_i  (wr_en_rf_i),
    .halt_core_i (halt_core_i),
    .imem_req_o  (imem_req_o),
    .ir_load_o   (ir_load_o),
    .alu_busy_o  (alu_busy_o),
    .rf_we_o     (rf_we_o),
    .pc_en_o     (pc_en_o),
    .halted_o    (halted_o),
    .fault_o     (fault_o),
    .state_o     (state_o),
    .retired_o   (retired_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit mul;
    bit wr;
    bit halt;
    int ack;
  } instr_t;

  typedef struct {
    bit rf;
    int lat;
    int ex;
    int ret;
  } wb_t;

  instr_t prog[$];
  wb_t    exp_q[$];
  int     cyc = 0;
  int     total = 0;
  int     passed = 0;
  int     wb_seen = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint req);
    total++;
    if (act == req) passed++;
    else $display("FAIL %s: got %0d want %0d", nm, act, req);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget,
                            input string nm);
    int n = 0;
    while (state_o != s && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    chk(nm, state_o, s);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // instruction memory + decoder model, driven per fetch
  initial begin : env
    instr_t cur;
    int     fcnt;
    cur = '{mul:0, wr:0, halt:1, ack:1};
    fcnt = 0;
    imem_ack_i = 0;
    mul_op_i = 0;
    wr_en_rf_i = 0;
    halt_core_i = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i || state_o != S_FETCH) begin
        imem_ack_i = 0;
        fcnt = 0;
      end else begin
        if (fcnt == 0) begin
          if (prog.size() > 0) cur = prog.pop_front();
          else cur = '{mul:0, wr:0, halt:1, ack:1};
          mul_op_i = cur.mul;
          wr_en_rf_i = cur.wr;
          halt_core_i = cur.halt;
        end
        imem_ack_i = (cur.ack != 0) && (fcnt == cur.ack - 1);
        fcnt++;
      end
    end
  end

  initial begin : monitor
    bit  in_f;
    int  fstart, busy;
    wb_t e;
    in_f = 0;
    fstart = 0;
    busy = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        in_f = 0;
        busy = 0;
      end else begin
        if (state_o == S_FETCH && !in_f) begin
          fstart = cyc;
          busy = 0;
        end
        in_f = (state_o == S_FETCH);
        if (alu_busy_o) busy++;
        if (pc_en_o || rf_we_o) begin
          wb_seen++;
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL wb_unexpected: pc_en=%0b rf_we=%0b want none",
                     pc_en_o, rf_we_o);
          end else begin
            e = exp_q.pop_front();
            chk("wb_pc_en", pc_en_o, 1);
            chk("wb_rf_we", rf_we_o, e.rf);
            chk("wb_latency", cyc - fstart + 1, e.lat);
            chk("wb_exec_cycles", busy, e.ex);
            chk("wb_retired", retired_o, e.ret);
          end
        end
      end
    end
  end

  initial begin : stim
    int n;
    rst_n_i = 0;
    run_i = 0;
    step_i = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_state", state_o, S_IDLE);
    chk("rst_outs", {imem_req_o, ir_load_o, alu_busy_o, rf_we_o,
                     pc_en_o, halted_o, fault_o}, 0);
    chk("rst_retired", retired_o, 0);
    tick();
    rst_n_i = 1;

    // reset lands mid-EXECUTE of a MUL
    prog.push_back('{mul:1, wr:1, halt:0, ack:1});
    run_i = 1;
    @(negedge clk_i);
    wait_state(S_EXEC, 10, "t1_reach_exec");
    #1 rst_n_i = 0;
    run_i = 0;
    #1;
    chk("t1_state", state_o, S_IDLE);
    chk("t1_outs", {imem_req_o, ir_load_o, alu_busy_o, rf_we_o,
                    pc_en_o, halted_o, fault_o}, 0);
    chk("t1_retired", retired_o, 0);
    tick();
    rst_n_i = 1;

    // ADD, ack on second request cycle, run dropped mid-instruction
    prog.push_back('{mul:0, wr:1, halt:0, ack:2});
    exp_q.push_back('{rf:1, lat:5, ex:1, ret:0});
    tick();
    run_i = 1;
    @(negedge clk_i);
    wait_state(S_FETCH, 5, "t2_fetch");
    run_i = 0;
    wait_state(S_IDLE, 20, "t2_idle");
    chk("t2_retired", retired_o, 1);

    // MUL then ADD back to back
    prog.push_back('{mul:1, wr:1, halt:0, ack:1});
    prog.push_back('{mul:0, wr:1, halt:0, ack:1});
    exp_q.push_back('{rf:1, lat:7, ex:4, ret:1});
    exp_q.push_back('{rf:1, lat:4, ex:1, ret:2});
    tick();
    run_i = 1;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!pc_en_o && n < 20);
    chk("t3_mul_wb", pc_en_o, 1);
    @(negedge clk_i);
    chk("t3_next_fetch", state_o, S_FETCH);
    run_i = 0;
    wait_state(S_IDLE, 20, "t3_idle");
    chk("t3_retired", retired_o, 3);

    // BEQ (no RF write) then HALT
    prog.push_back('{mul:0, wr:0, halt:0, ack:1});
    prog.push_back('{mul:0, wr:1, halt:1, ack:1});
    exp_q.push_back('{rf:0, lat:4, ex:1, ret:3});
    tick();
    run_i = 1;
    @(negedge clk_i);
    wait_state(S_HALTED, 30, "t4_halted_state");
    chk("t4_halted", halted_o, 1);
    chk("t4_fault", fault_o, 0);
    chk("t4_retired", retired_o, 4);
    run_i = 0;
    step_i = 1;
    repeat (2) @(negedge clk_i);
    run_i = 1;
    step_i = 0;
    repeat (4) @(negedge clk_i);
    chk("t4_sticky", state_o, S_HALTED);
    chk("t4_strobes", {imem_req_o, rf_we_o, pc_en_o, alu_busy_o}, 0);
    run_i = 0;
    #1 rst_n_i = 0;
    #1;
    chk("t4_rst_state", state_o, S_IDLE);
    chk("t4_rst_retired", retired_o, 0);
    tick();
    rst_n_i = 1;

    // single step, second step during FETCH is dropped
    prog.push_back('{mul:0, wr:1, halt:0, ack:3});
    exp_q.push_back('{rf:1, lat:6, ex:1, ret:0});
    tick();
    step_i = 1;
    tick();
    step_i = 0;
    tick();
    chk("t5_in_fetch", state_o, S_FETCH);
    step_i = 1;
    tick();
    step_i = 0;
    wait_state(S_IDLE, 20, "t5_idle");
    repeat (5) @(negedge clk_i);
    chk("t5_stays_idle", state_o, S_IDLE);
    chk("t5_retired", retired_o, 1);
    prog.push_back('{mul:0, wr:0, halt:0, ack:1});
    exp_q.push_back('{rf:0, lat:4, ex:1, ret:1});
    tick();
    step_i = 1;
    tick();
    step_i = 0;
    wait_state(S_IDLE, 20, "t5_idle2");
    repeat (3) @(negedge clk_i);
    chk("t5_retired2", retired_o, 2);

    // fetch never acknowledged -> FAULT
    prog.push_back('{mul:0, wr:1, halt:0, ack:0});
    tick();
    run_i = 1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (imem_req_o) n++;
      if (fault_o) break;
    end
    chk("t6_req_cycles", n, 16);
    chk("t6_fault", fault_o, 1);
    chk("t6_halted", halted_o, 1);
    chk("t6_req_off", imem_req_o, 0);
    chk("t6_state", state_o, S_FAULT);
    run_i = 0;
    step_i = 1;
    repeat (2) @(negedge clk_i);
    step_i = 0;
    run_i = 1;
    repeat (5) @(negedge clk_i);
    chk("t6_sticky", state_o, S_FAULT);
    chk("t6_fault_held", fault_o, 1);
    run_i = 0;

    chk("sb_drained", exp_q.size(), 0);
    chk("wb_count", wb_seen, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
